// File: rtl/rdc_pkg.sv
// Shared types and sizing helpers for the RDC interrupt event logger.
package rdc_pkg;

    localparam int N_CORES_DEF     = 2;
    localparam int CORE_EVENTS_DEF = 4;
    localparam int TS_WIDTH_DEF    = 32;

    // Width of a flat flag index; a single flag still needs one bit.
    function automatic int id_width(input int n_flags);
        return (n_flags > 1) ? $clog2(n_flags) : 1;
    endfunction

    localparam int N_FLAGS_DEF  = N_CORES_DEF * CORE_EVENTS_DEF;
    localparam int ID_WIDTH_DEF = id_width(N_FLAGS_DEF);

    typedef struct packed {
        logic [ID_WIDTH_DEF-1:0] id;
        logic [TS_WIDTH_DEF-1:0] ts;
    } rdc_log_entry_t;

endpackage

// File: rtl/rdc_log_fifo.sv
// First-word-fall-through log FIFO; push into a full FIFO is accepted only
// when a pop frees the head slot in the same cycle.
module rdc_log_fifo import rdc_pkg::*; #(
    parameter int  DEPTH   = 8,
    parameter type entry_t = rdc_log_entry_t,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          flush_i,
    input  logic          push_i,
    input  entry_t        push_data_i,
    input  logic          pop_i,
    output entry_t        head_o,
    output logic          empty_o,
    output logic          full_o,
    output logic [AW:0]   count_o
);

    entry_t      mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic        do_push, do_pop;

    assign count_o = wr_ptr_q - rd_ptr_q;
    assign empty_o = (count_o == '0);
    assign full_o  = count_o[AW];
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // NOTE: storage has no reset; the pointers define validity and head_o is masked when empty.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/rdc_irq_logger.sv
// Turns rising RDC overrun flags into time-stamped log entries, one per
// flag, drained by software through a FWFT FIFO with a level interrupt.
module rdc_irq_logger import rdc_pkg::*; #(
    parameter int  N_CORES     = N_CORES_DEF,
    parameter int  CORE_EVENTS = CORE_EVENTS_DEF,
    parameter int  TS_WIDTH    = TS_WIDTH_DEF,
    parameter int  FIFO_DEPTH  = 8,
    parameter int  DROP_WIDTH  = 8,
    localparam int N_FLAGS     = N_CORES * CORE_EVENTS,
    localparam int ID_WIDTH    = id_width(N_FLAGS),
    localparam int CNT_WIDTH   = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  enable_i,
    input  logic                  clear_i,
    input  logic [N_FLAGS-1:0]    irq_vector_i,
    output logic                  rd_valid_o,
    input  logic                  rd_ready_i,
    output logic [ID_WIDTH-1:0]   rd_id_o,
    output logic [TS_WIDTH-1:0]   rd_ts_o,
    output logic [CNT_WIDTH-1:0]  count_o,
    output logic                  overflow_o,
    output logic [DROP_WIDTH-1:0] drop_cnt_o,
    output logic                  irq_o
);

    localparam int INC_W = $clog2(N_FLAGS + 2);
    localparam int SUM_W = DROP_WIDTH + INC_W;

    typedef struct packed {
        logic [ID_WIDTH-1:0] id;
        logic [TS_WIDTH-1:0] ts;
    } entry_t;

    logic [TS_WIDTH-1:0]   ts_q, ts_d;
    logic [N_FLAGS-1:0]    prev_q, prev_d, pend_q, pend_d;
    logic [N_FLAGS-1:0]    new_edge, merge, sel;
    logic [TS_WIDTH-1:0]   ts_cap_q [N_FLAGS];
    logic [ID_WIDTH-1:0]   sel_id;
    logic                  push_req, accepted, discard, pop;
    logic                  fifo_full, fifo_empty;
    logic                  overflow_q, overflow_d;
    logic [DROP_WIDTH-1:0] drop_q, drop_d;
    logic [INC_W-1:0]      inc;
    logic [SUM_W-1:0]      drop_sum;
    entry_t                push_entry, head;

    assign rd_valid_o = ~fifo_empty;
    assign irq_o      = rd_valid_o;
    assign pop        = rd_valid_o & rd_ready_i;
    assign rd_id_o    = head.id;
    assign rd_ts_o    = head.ts;
    assign overflow_o = overflow_q;
    assign drop_cnt_o = drop_q;

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        new_edge = enable_i ? (irq_vector_i & ~prev_q) : '0;
        merge    = new_edge & pend_q;
        // Isolate the lowest set pending bit: that flag is serialized this cycle.
        sel      = pend_q & (~pend_q + N_FLAGS'(1));
        sel_id   = '0;
        for (int k = N_FLAGS - 1; k >= 0; k--) begin
            if (pend_q[k]) sel_id = ID_WIDTH'(k);
        end

        push_req   = enable_i & ~clear_i & (|pend_q);
        accepted   = push_req & (~fifo_full | pop);
        discard    = push_req & ~accepted;
        push_entry = '{id: sel_id, ts: ts_cap_q[sel_id]};

        inc = INC_W'(discard);
        for (int k = 0; k < N_FLAGS; k++) begin
            inc = inc + INC_W'(merge[k]);
        end
        drop_sum = SUM_W'(drop_q) + SUM_W'(inc);

        prev_d = enable_i ? irq_vector_i : '0;
        if (clear_i || !enable_i) pend_d = '0;
        else                      pend_d = (pend_q & ~sel) | (new_edge & ~pend_q);

        if (clear_i)       ts_d = '0;
        else if (enable_i) ts_d = ts_q + 1'b1;
        else               ts_d = ts_q;

        if (clear_i) begin
            overflow_d = 1'b0;
            drop_d     = '0;
        end else begin
            overflow_d = overflow_q | discard;
            drop_d     = (drop_sum[SUM_W-1:DROP_WIDTH] != '0) ? '1 : drop_sum[DROP_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ts_q       <= '0;
            prev_q     <= '0;
            pend_q     <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            ts_q       <= ts_d;
            prev_q     <= prev_d;
            pend_q     <= pend_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    // A merged edge keeps the timestamp of the edge that is still waiting.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int k = 0; k < N_FLAGS; k++) ts_cap_q[k] <= '0;
        end else begin
            for (int k = 0; k < N_FLAGS; k++) begin
                if (new_edge[k] && !pend_q[k]) ts_cap_q[k] <= ts_q;
            end
        end
    end

    rdc_log_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .flush_i     (clear_i),
        .push_i      (accepted),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (head),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full),
        .count_o     (count_o)
    );

endmodule
